weight_loader: RTL and testbench

//  Fetch engine that fills the 6-slot x 72-bit weight buffer from byte-wide weight memory.
//  On start, reads 9 signed 8-bit taps per 3x3 kernel from consecutive addresses.

---
 rtl/weight_loader.sv | 147 ++++++++++++++
 tb/tb_weight_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Weight loader: reads TAPS bytes per kernel from weight memory and writes one packed word per kernel
// into the weight buffer. Optional tap checksum is enabled with `define WLOAD_CHECKSUM_EN.
module weight_loader #(
    parameter int WEIGHT_W  = 8,
    parameter int TAPS      = 9,
    parameter int NUM_SLOTS = 6,
    parameter int ADDR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [2:0]               num_kernels,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_valid,
    input  logic [WEIGHT_W-1:0]      mem_rdata,
    output logic                     buf_wr,
    output logic [2:0]               buf_index,
    output logic [TAPS*WEIGHT_W-1:0] buf_data,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              checksum
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, FIN} state_t;

    state_t                   state;
    logic [2:0]               nk;
    logic [2:0]               slot;
    logic [3:0]               tap;
    logic [ADDR_W-1:0]        cur_addr;
    logic [TAPS*WEIGHT_W-1:0] pack;
    logic [TAPS*WEIGHT_W-1:0] pack_next;
    logic [2:0]               nk_clamped;

    always_comb begin
        nk_clamped = (num_kernels > 3'(NUM_SLOTS)) ? 3'(NUM_SLOTS) : num_kernels;
    end

    // Pack word with the incoming tap merged in, so the final tap reaches buf_data on the same edge
    always_comb begin
        pack_next = pack;
        pack_next[tap*WEIGHT_W +: WEIGHT_W] = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            nk        <= '0;
            slot      <= '0;
            tap       <= '0;
            cur_addr  <= '0;
            pack      <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            buf_wr    <= 1'b0;
            buf_index <= '0;
            buf_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr <= base_addr;
                        nk       <= nk_clamped;
                        slot     <= '0;
                        tap      <= '0;
                        busy     <= 1'b1;
                        if (nk_clamped == 3'd0) begin
                            state <= FIN;
                        end else begin
                            state    <= REQ;
                            mem_rd   <= 1'b1;
                            mem_addr <= base_addr;
                        end
                    end
                end
                REQ: begin
                    mem_rd <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (mem_valid) begin
                        pack     <= pack_next;
                        cur_addr <= cur_addr + 1'b1;
                        if (tap == 4'(TAPS-1)) begin
                            tap       <= '0;
                            state     <= WRITE;
                            buf_wr    <= 1'b1;
                            buf_index <= slot;
                            buf_data  <= pack_next;
                        end else begin
                            tap      <= tap + 4'd1;
                            state    <= REQ;
                            mem_rd   <= 1'b1;
                            mem_addr <= cur_addr + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    buf_wr <= 1'b0;
                    if (slot == nk - 3'd1) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        slot     <= slot + 3'd1;
                        state    <= REQ;
                        mem_rd   <= 1'b1;
                        mem_addr <= cur_addr;
                    end
                end
                FIN: begin
                    // An empty load enters FIN with done low and spends one extra cycle raising it
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (state == IDLE && start) begin
            csum <= '0;
        end else if (state == WAIT && mem_valid) begin
            csum <= csum + 16'(mem_rdata);
        end
    end

    assign checksum = csum;
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader with a latency-configurable byte memory model.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [2:0]  num_kernels = '0;
    logic        mem_rd;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_rdata;
    logic        buf_wr;
    logic [2:0]  buf_index;
    logic [71:0] buf_data;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int startCycle = 0;
    int doneCycle = 0;
    int readCount = 0;
    int writeCount = 0;
    int violations = 0;
    bit outstanding = 1'b0;
    logic [15:0] addrLog [64];
    logic [2:0]  idxLog [16];
    logic [71:0] dataLog [16];

    int         memLat = 1;
    bit         memRandom = 1'b0;
    logic [7:0] memOffset = '0;

    weight_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .num_kernels (num_kernels),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .buf_wr      (buf_wr),
        .buf_index   (buf_index),
        .buf_data    (buf_data),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Byte memory: answers each read after memLat (or a random 1-5) cycles with addr[7:0]+memOffset
    initial begin
        logic [15:0] reqAddr;
        int lat;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            if (mem_rd === 1'b1 && rst_n === 1'b1) begin
                reqAddr = mem_addr;
                lat = memRandom ? int'($urandom_range(1, 5)) : memLat;
                repeat (lat) @(posedge clk);
                #1;
                mem_valid = 1'b1;
                mem_rdata = reqAddr[7:0] + memOffset;
            end
        end
    end

    // Bus monitor: logs reads and buffer writes, flags a second read issued before data returned
    always @(negedge clk) begin
        if (!rst_n) begin
            outstanding = 1'b0;
        end else begin
            if (mem_valid) outstanding = 1'b0;
            if (mem_rd) begin
                if (outstanding) violations++;
                outstanding = 1'b1;
                if (readCount < 64) addrLog[readCount] = mem_addr;
                readCount++;
            end
            if (buf_wr) begin
                if (writeCount < 16) begin
                    idxLog[writeCount]  = buf_index;
                    dataLog[writeCount] = buf_data;
                end
                writeCount++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic resetCounters();
        readCount  = 0;
        writeCount = 0;
        violations = 0;
    endtask

    task automatic applyStimulus(input logic [15:0] base, input logic [2:0] nk);
        @(posedge clk);
        #1;
        start       = 1'b1;
        base_addr   = base;
        num_kernels = nk;
        startCycle  = cycleCount;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < budget);
        checkOutput("done_seen", 72'(done), 72'd1);
        doneCycle = cycleCount;
    endtask

    initial begin
        logic [15:0] expSum;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_rd",  72'(mem_rd), 72'd0);
        checkOutput("rst_busy",    72'(busy), 72'd0);
        checkOutput("rst_buf_data", buf_data, 72'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Reset while waiting on a slow read aborts the load
        memLat = 5;
        memOffset = 8'd1;
        resetCounters();
        applyStimulus(16'h0100, 3'd1);
        @(negedge clk);
        checkOutput("abort_busy_before", 72'(busy), 72'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_mem_rd",   72'(mem_rd), 72'd0);
        checkOutput("abort_mem_addr", 72'(mem_addr), 72'd0);
        checkOutput("abort_busy",     72'(busy), 72'd0);
        checkOutput("abort_done",     72'(done), 72'd0);
        checkOutput("abort_buf_wr",   72'(buf_wr), 72'd0);
        checkOutput("abort_checksum", 72'(checksum), 72'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);

        // Single kernel, 1-cycle memory
        memLat = 1;
        resetCounters();
        applyStimulus(16'h0100, 3'd1);
        waitDone(100);
        checkOutput("k1_done_cycle", 72'(doneCycle - startCycle), 72'd20);
        checkOutput("k1_busy_at_done", 72'(busy), 72'd1);
        checkOutput("k1_reads", 72'(readCount), 72'd9);
        checkOutput("k1_addr_first", 72'(addrLog[0]), 72'h0100);
        checkOutput("k1_addr_last", 72'(addrLog[8]), 72'h0108);
        checkOutput("k1_writes", 72'(writeCount), 72'd1);
        checkOutput("k1_index", 72'(idxLog[0]), 72'd0);
        checkOutput("k1_data", dataLog[0], 72'h090807060504030201);
`ifdef WLOAD_CHECKSUM_EN
        checkOutput("k1_checksum", 72'(checksum), 72'd45);
`else
        checkOutput("k1_checksum", 72'(checksum), 72'd0);
`endif
        // Start coincident with done must be ignored
        start       = 1'b1;
        num_kernels = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("k1_busy_after", 72'(busy), 72'd0);
        checkOutput("k1_done_pulse", 72'(done), 72'd0);
        checkOutput("k1_buf_hold", buf_data, 72'h090807060504030201);
        repeat (3) @(negedge clk);
        checkOutput("coincident_start_ignored", 72'(readCount), 72'd9);

        // Full six-kernel load, mem[a]=a[7:0]
        memOffset = 8'd0;
        resetCounters();
        applyStimulus(16'h0000, 3'd6);
        waitDone(400);
        checkOutput("k6_done_cycle", 72'(doneCycle - startCycle), 72'd115);
        checkOutput("k6_reads", 72'(readCount), 72'd54);
        checkOutput("k6_writes", 72'(writeCount), 72'd6);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("k6_index%0d", i), 72'(idxLog[i]), 72'(i));
        checkOutput("k6_slot0", dataLog[0], 72'h080706050403020100);
        checkOutput("k6_slot5", dataLog[5], 72'h3534333231302F2E2D);
`ifdef WLOAD_CHECKSUM_EN
        expSum = 16'd1431;
`else
        expSum = 16'd0;
`endif
        checkOutput("k6_checksum", 72'(checksum), 72'(expSum));

        // Clamp and random stalls
        memRandom = 1'b1;
        resetCounters();
        repeat (2) @(posedge clk);
        applyStimulus(16'h0000, 3'd7);
        waitDone(2000);
        checkOutput("k7_reads", 72'(readCount), 72'd54);
        checkOutput("k7_writes", 72'(writeCount), 72'd6);
        checkOutput("k7_overlap", 72'(violations), 72'd0);
        checkOutput("k7_slot5", dataLog[5], 72'h3534333231302F2E2D);
        checkOutput("k7_index5", 72'(idxLog[5]), 72'd5);
        memRandom = 1'b0;
        repeat (8) @(posedge clk);

        // Zero kernels
        resetCounters();
        applyStimulus(16'h1234, 3'd0);
        waitDone(20);
        checkOutput("k0_done_cycle", 72'(doneCycle - startCycle), 72'd2);
        checkOutput("k0_reads", 72'(readCount), 72'd0);
        checkOutput("k0_writes", 72'(writeCount), 72'd0);
        checkOutput("k0_checksum", 72'(checksum), 72'd0);
        repeat (2) @(posedge clk);

        // Start while busy is ignored
        memOffset = 8'd1;
        resetCounters();
        applyStimulus(16'h0100, 3'd1);
        repeat (4) @(posedge clk);
        #1;
        start       = 1'b1;
        base_addr   = 16'h0000;
        num_kernels = 3'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(100);
        checkOutput("busy_done_cycle", 72'(doneCycle - startCycle), 72'd20);
        repeat (4) @(negedge clk);
        checkOutput("busy_reads", 72'(readCount), 72'd9);
        checkOutput("busy_writes", 72'(writeCount), 72'd1);
        checkOutput("busy_data", dataLog[0], 72'h090807060504030201);

        // Address wrap
        memOffset = 8'd0;
        resetCounters();
        applyStimulus(16'hFFFC, 3'd1);
        waitDone(100);
        checkOutput("wrap_addr0", 72'(addrLog[0]), 72'hFFFC);
        checkOutput("wrap_addr4", 72'(addrLog[4]), 72'h0000);
        checkOutput("wrap_addr8", 72'(addrLog[8]), 72'h0004);
        checkOutput("wrap_data", dataLog[0], 72'h0403020100FFFEFDFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
